// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu front end: default widths, fetch FSM
// encoding and the {pc, instr} entry carried from fetch to decode.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [1:0] IFETCH_IDLE  = 2'd0;
    localparam logic [1:0] IFETCH_WAIT  = 2'd1;
    localparam logic [1:0] IFETCH_DRAIN = 2'd2;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } ifetch_entry_t;

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Prefetch FIFO between instruction memory and decode. The head is read
// straight from the storage registers; flush empties it in one cycle.
module cpu_ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(w_pop);
        end
    end

    // When full, push and pop share a slot: the head is read before the write lands.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch: one outstanding word-addressed request, slot reserved
// at issue, redirect flushes the prefetch FIFO and drains any in-flight fetch.
module cpu_ifetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  fetch_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]                r_state;
    logic [ADDR_W-1:0]         r_fetch_pc;
    logic [ADDR_W-1:0]         r_req_addr;

    logic                      w_outstanding;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_valid;
    logic [CNT_W-1:0]          w_count;
    logic [CNT_W-1:0]          w_cnt_after;
    logic                      w_slot_free;
    logic [ADDR_W+INSTR_W-1:0] w_head;

    assign w_outstanding = (r_state != IFETCH_IDLE);
    assign w_push        = (r_state == IFETCH_WAIT) && imem_ack && !redirect_valid;
    assign w_pop         = w_fifo_valid && instr_ready;

    // Occupancy after this edge; a slot is only free if it is not already reserved.
    assign w_cnt_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_slot_free = (w_cnt_after < CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IFETCH_IDLE;
            r_fetch_pc <= '0;
            r_req_addr <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            if (w_outstanding && !imem_ack) begin
                r_state <= IFETCH_DRAIN;
            end else begin
                r_state    <= IFETCH_WAIT;
                r_req_addr <= redirect_pc;
            end
        end else begin
            case (r_state)
                IFETCH_IDLE: begin
                    if (w_slot_free) begin
                        r_state    <= IFETCH_WAIT;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                IFETCH_WAIT: begin
                    if (imem_ack) begin
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                        r_req_addr <= r_fetch_pc + ADDR_W'(1);
                        r_state    <= w_slot_free ? IFETCH_WAIT : IFETCH_IDLE;
                    end
                end
                IFETCH_DRAIN: begin
                    // Stale word is dropped; fetch_pc already holds the latest target.
                    if (imem_ack) begin
                        r_state    <= IFETCH_WAIT;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                default: r_state <= IFETCH_IDLE;
            endcase
        end
    end

    cpu_ifetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_req_addr, imem_rdata}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

    assign imem_req    = w_outstanding;
    assign imem_addr   = r_req_addr;
    assign instr_valid = w_fifo_valid;
    assign instr_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr       = w_head[INSTR_W-1:0];
    assign fetch_pc    = r_fetch_pc;

endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
- Instruction fetch stage directly upstream of the cpu decode/execute path.
- Generates word-addressed fetch requests to instruction memory, buffers the returned words in a small prefetch FIFO, and presents {instr, instr_pc} to the decoder with a valid/ready handshake.
- Accepts a branch/jump redirect from the execute stage, which flushes the FIFO and any in-flight fetch.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  execute stage requests PC change this cycle
- redirect_pc  in  ADDR_W  new fetch address
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  word address of request
- imem_ack  in  1  memory completes request this cycle
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1
- instr_valid  out  1  FIFO head holds a valid instruction
- instr  out  INSTR_W  FIFO head instruction
- instr_pc  out  ADDR_W  address of FIFO head instruction
- instr_ready  in  1  decoder accepts head this cycle
- fetch_pc  out  ADDR_W  next address to be requested (debug/observability)

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=0, FIFO empty, state=IDLE, imem_req=0, instr_valid=0. Reset mid-transfer abandons it; a late imem_ack after reset is ignored.
- Word addressing: each fetch advances fetch_pc by 1, modulo 2^ADDR_W. 0xFFFF wraps to 0x0000 with no flag.
- At most one fetch is outstanding at a time.
- A FIFO slot is reserved at issue, so a fetch issues only if count < DEPTH.
- The FIFO counts an entry popped in the same cycle as free.
- State machine:
  - IDLE: imem_req=0. Moves to WAIT in the next cycle when a slot is free and redirect_valid=0.
  - WAIT: imem_req=1 and imem_addr=the issued address, both stable until imem_ack. Ack in the same cycle as the request is legal. On imem_ack, {imem_rdata, addr} is pushed, fetch_pc increments, and the block returns to IDLE, or stays in WAIT with the next address if a slot is still free (back-to-back throughput of 1 word/cycle with zero-latency memory).
  - DRAIN: entered from WAIT on redirect. imem_req stays high with the old address until imem_ack, because a request cannot be aborted. The ack data is discarded. The next state is WAIT for the redirect address.
- Output handshake: a pop occurs when instr_valid and instr_ready are both 1. instr and instr_pc are the registered FIFO head, and no combinational path exists from imem_rdata to instr. Push and pop in the same cycle are allowed at any count, including full.
- Redirect (highest priority after rst):
  - In cycle N it flushes the FIFO, discards any imem_ack from WAIT, and loads fetch_pc=redirect_pc.
  - instr_valid is 0 from N+1 until the first post-redirect word is pushed.
  - A pop handshake in cycle N is treated as consumed by the decoder, and the FIFO is cleared regardless.
  - With no outstanding fetch, imem_req is asserted with redirect_pc at N+1.
  - Redirect during DRAIN replaces the pending target address. The latest redirect wins.
- Minimum latency from a redirect with idle memory and zero-latency ack: instr_valid=1 at N+2.
- No overflow is possible by construction. The bench asserts that a push never occurs while count==DEPTH without a same-cycle pop.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - Fetch state encoding: IFETCH_IDLE, IFETCH_WAIT, IFETCH_DRAIN.
  - A fetch-entry struct {pc, instr}.
- One natural sub-module: cpu_ifetch_fifo. It is a synchronous DEPTH-entry FIFO with a flush input, push/pop, count, and registered head output.

Test Plan:
- Reset then free run: zero-latency memory returning rdata=addr+16'h1000, instr_ready=1 → the decoder receives pc 0,1,2,3… with instr 0x1000,0x1001…, first instr_valid at cycle 2 after rst deasserts, one instruction per cycle thereafter.
- Backpressure: instr_ready=0 for 10 cycles → exactly DEPTH=4 words are fetched (pc 0–3), imem_req=0 while full. On release, the words come out in order and fetching resumes at pc 4.
- Slow memory: ack 3 cycles after req → imem_addr is held stable throughout, one word every 3 cycles, no duplicated or skipped pc.
- Redirect with idle memory: redirect_pc=0x0040 while FIFO holds pc 5–8 → instr_valid drops next cycle, imem_addr=0x0040 on the next cycle, and the next accepted instr_pc is 0x0040.
- Redirect during outstanding fetch: redirect to 0x0100 while the fetch for pc 7 waits 2 more cycles → the pc 7 data is never presented, the next request is 0x0100, and the first output is 0x0100.
- Wrap and reset mid-operation: redirect to 0xFFFE → outputs 0xFFFE, 0xFFFF, 0x0000. Asserting rst while a fetch is outstanding → all outputs return to reset values next cycle, and the late ack is ignored.
